// File: rtl/uart_tx_bus.sv
// 8N1 UART transmitter fed by a small circular FIFO written from the CPU bus.
// Single clock domain; every output is registered, so Wr_En/Wr_Data never reach Tx combinationally.
module uart_tx_bus #(
    parameter int unsigned ClkDiv    = 434,
    parameter int unsigned FifoDepth = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Wr_En,
    input  logic [7:0] Wr_Data,
    output logic       Full,
    output logic       Busy,
    output logic       Overflow,
    output logic       Tx
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = 16;
    localparam logic [BW-1:0] BaudLoad = BW'(ClkDiv - 1);
    localparam logic [CW-1:0] CntFull  = CW'(FifoDepth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
    logic [CW-1:0]   count, count_nx;
    logic [BW-1:0]   baud, baud_nx;
    logic [2:0]      bit_idx, bit_idx_nx;
    logic [7:0]      shift, shift_nx;
    logic            tx_nx, full_nx, busy_nx, ovf_nx;
    logic            push, pop;
    logic [7:0]      mem [FifoDepth];

    // FIFO storage; pointers are reset separately so contents need no clear
    always_ff @(posedge Clock) begin
        if (Reset && push) begin
            mem[wr_ptr] <= Wr_Data;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            Tx       <= 1'b1;
            Full     <= 1'b0;
            Busy     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            count    <= count_nx;
            baud     <= baud_nx;
            bit_idx  <= bit_idx_nx;
            shift    <= shift_nx;
            Tx       <= tx_nx;
            Full     <= full_nx;
            Busy     <= busy_nx;
            Overflow <= ovf_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        baud_nx    = baud;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        pop        = 1'b0;
        push       = Wr_En && !Full;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    baud_nx  = BaudLoad;
                    state_nx = START;
                end
            end
            START: begin
                if (baud == '0) begin
                    baud_nx    = BaudLoad;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end else begin
                    baud_nx = baud - BW'(1);
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_nx = BaudLoad;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        shift_nx   = {1'b0, shift[7:1]};
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nx = baud - BW'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more data is queued
                if (baud == '0) begin
                    if (count != '0) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr];
                        baud_nx  = BaudLoad;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    baud_nx = baud - BW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        wr_ptr_nx = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_nx = pop  ? rd_ptr + AW'(1) : rd_ptr;

        case ({push, pop})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase

        full_nx = (count_nx == CntFull);
        busy_nx = (state_nx != IDLE) || (count_nx != '0);
        ovf_nx  = Overflow || (Wr_En && Full);

        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

endmodule
